// File: rtl/blink_sequencer.sv
// Command-driven four-LED sequencer: saturating speed setting, run/pause control,
// a two-stage prescaler producing pattern-step ticks, and four selectable patterns.
module blink_sequencer #(
  parameter int          BASE_CYCLES = 3_125_000,
  parameter logic [3:0]  DELAY_INIT  = 4'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       faster,
  input  logic       slower,
  input  logic       pause,
  input  logic       mode,
  output logic [3:0] led,
  output logic [3:0] delay,
  output logic [1:0] pattern,
  output logic       paused,
  output logic       tick
);

  localparam int            BW        = (BASE_CYCLES > 1) ? $clog2(BASE_CYCLES) : 1;
  localparam logic [BW-1:0] BASE_LAST = BW'(BASE_CYCLES - 1);

  typedef enum logic {RUN, PAUSED} state_t;
  typedef enum logic [1:0] {PAT_SHIFT, PAT_BOUNCE, PAT_COUNT, PAT_FLASH} pattern_t;

  state_t        state_q, state_d;
  pattern_t      pattern_q, pattern_d;
  logic [BW-1:0] base_q, base_d;
  logic [3:0]    step_q, step_d;
  logic [3:0]    led_q, led_d;
  logic [3:0]    delay_q, delay_d;
  logic          dir_up_q, dir_up_d;
  logic          tick_q, tick_d;
  logic          base_wrap;
  logic          step_evt;

  always_comb begin
    delay_d = delay_q;
    if (faster && !slower && delay_q != 4'd0)
      delay_d = delay_q - 4'd1;
    else if (slower && !faster && delay_q != 4'd15)
      delay_d = delay_q + 4'd1;

    // >= rather than == so a delay drop below the step count fires at the next wrap
    base_wrap = (base_q == BASE_LAST);
    step_evt  = (state_q == RUN) && base_wrap && (step_q >= delay_q);

    state_d   = state_q;
    pattern_d = pattern_q;
    base_d    = base_q;
    step_d    = step_q;
    led_d     = led_q;
    dir_up_d  = dir_up_q;
    tick_d    = 1'b0;

    if (mode) begin
      pattern_d = pattern_t'(pattern_q + 2'd1);
      base_d    = '0;
      step_d    = 4'd0;
      dir_up_d  = 1'b1;
      case (pattern_d)
        PAT_SHIFT:  led_d = 4'b0001;
        PAT_BOUNCE: led_d = 4'b0001;
        PAT_COUNT:  led_d = 4'b0000;
        default:    led_d = 4'b1111;
      endcase
      if (pause)
        state_d = (state_q == RUN) ? PAUSED : RUN;
    end else if (pause) begin
      state_d = (state_q == RUN) ? PAUSED : RUN;
    end else if (step_evt) begin
      base_d = '0;
      step_d = 4'd0;
      tick_d = 1'b1;
      case (pattern_q)
        PAT_SHIFT:  led_d = {led_q[2:0], led_q[3]};
        PAT_BOUNCE: begin
          if (dir_up_q) begin
            led_d = led_q << 1;
            if (led_d[3])
              dir_up_d = 1'b0;
          end else begin
            led_d = led_q >> 1;
            if (led_d[0])
              dir_up_d = 1'b1;
          end
        end
        PAT_COUNT:  led_d = led_q + 4'd1;
        default:    led_d = ~led_q;
      endcase
    end else if (state_q == RUN) begin
      if (base_wrap) begin
        base_d = '0;
        step_d = step_q + 4'd1;
      end else begin
        base_d = base_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      pattern_q <= PAT_SHIFT;
      base_q    <= '0;
      step_q    <= 4'd0;
      led_q     <= 4'b0001;
      delay_q   <= DELAY_INIT;
      dir_up_q  <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      base_q    <= base_d;
      step_q    <= step_d;
      led_q     <= led_d;
      delay_q   <= delay_d;
      dir_up_q  <= dir_up_d;
      tick_q    <= tick_d;
    end
  end

  assign led     = led_q;
  assign delay   = delay_q;
  assign pattern = pattern_q;
  assign paused  = (state_q == PAUSED);
  assign tick    = tick_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Scoreboard bench for blink_sequencer: a behavioural model predicts every cycle's
// outputs, a monitor process compares them against the DUT just after each edge.
module tb_blink_sequencer;

  localparam int BASE = 4;

  typedef struct packed {
    logic [3:0] led;
    logic [3:0] delay;
    logic [1:0] pattern;
    logic       paused;
    logic       tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       faster = 1'b0;
  logic       slower = 1'b0;
  logic       pause = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] led;
  logic [3:0] delay;
  logic [1:0] pattern;
  logic       paused;
  logic       tick;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // Model state: elapsed counts running clocks since the last step/clear.
  int m_led = 1;
  int m_delay = 7;
  int m_pattern = 0;
  int m_paused = 0;
  int m_elapsed = 0;
  int m_bpos = 0;
  int m_tick = 0;
  int bseq[6] = '{1, 2, 4, 8, 4, 2};

  blink_sequencer #(.BASE_CYCLES(BASE), .DELAY_INIT(4'd7)) dut (
    .clk(clk), .reset(reset), .faster(faster), .slower(slower),
    .pause(pause), .mode(mode), .led(led), .delay(delay),
    .pattern(pattern), .paused(paused), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic modelStep(input logic r, input logic f, input logic s,
                           input logic p, input logic md);
    int nd;
    bit evt;
    if (r) begin
      m_led = 1; m_delay = 7; m_pattern = 0; m_paused = 0;
      m_elapsed = 0; m_bpos = 0; m_tick = 0;
      return;
    end
    nd = m_delay;
    if (f && !s) nd = (m_delay > 0) ? m_delay - 1 : 0;
    else if (s && !f) nd = (m_delay < 15) ? m_delay + 1 : 15;
    evt = (m_paused == 0) && (m_elapsed % BASE == BASE - 1) && (m_elapsed / BASE >= m_delay);
    m_tick = 0;
    if (md) begin
      m_pattern = (m_pattern + 1) % 4;
      m_elapsed = 0;
      m_bpos = 0;
      m_led = (m_pattern == 2) ? 0 : (m_pattern == 3) ? 15 : 1;
      if (p) m_paused = 1 - m_paused;
    end else if (p) begin
      m_paused = 1 - m_paused;
    end else if (evt) begin
      m_elapsed = 0;
      m_tick = 1;
      case (m_pattern)
        0: m_led = (m_led == 8) ? 1 : m_led * 2;
        1: begin m_bpos = (m_bpos + 1) % 6; m_led = bseq[m_bpos]; end
        2: m_led = (m_led + 1) % 16;
        default: m_led = 15 - m_led;
      endcase
    end else if (m_paused == 0) begin
      m_elapsed++;
    end
    m_delay = nd;
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the next edge must produce.
  task automatic applyStimulus(input logic r, input logic f, input logic s,
                               input logic p, input logic md);
    exp_t e;
    @(negedge clk);
    reset = r; faster = f; slower = s; pause = p; mode = md;
    modelStep(r, f, s, p, md);
    e.led = 4'(m_led);
    e.delay = 4'(m_delay);
    e.pattern = 2'(m_pattern);
    e.paused = (m_paused != 0);
    e.tick = (m_tick != 0);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input exp_t e);
    n_vec++;
    if (led !== e.led || delay !== e.delay || pattern !== e.pattern ||
        paused !== e.paused || tick !== e.tick) begin
      n_bad++;
      $display("[TB] FAIL outputs cycle %0d: got led=%b delay=%0d pattern=%0d paused=%b tick=%b, want led=%b delay=%0d pattern=%0d paused=%b tick=%b",
               cyc, led, delay, pattern, paused, tick,
               e.led, e.delay, e.pattern, e.paused, e.tick);
    end
  endtask

  // Monitor: every edge yields one output vector; pop its prediction and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    // Reset and first ticks at the default delay
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(70);

    // Delay saturation in both directions, then a cancelling faster+slower pair
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(140);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);

    // Pattern cycle at delay 0
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(30);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(70);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(12);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(8);

    // Pause 10 clocks into a 32-clock period, hold, resume
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(30);

    // mode on the tick edge, then pause on the tick edge
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(31);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(31);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);

    // Mid-period delay drop from 15 with the step counter at 9
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(29);
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(20);

    // Reset while bouncing downward
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(18);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(5);

    // Random command pulses
    for (int i = 0; i < 2500; i++)
      applyStimulus($urandom_range(399) == 0, $urandom_range(11) == 0,
                    $urandom_range(11) == 0, $urandom_range(39) == 0,
                    $urandom_range(49) == 0);

    @(posedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
